// File: rtl/vscpu_irq_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vscpu_irq_core                                                           |
// | Four-cycle multi-state VSCPU core with a single-level interrupt.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vscpu_irq_core #(
    parameter int                ADDR_W       = 14,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W-1:0] IRQ_RET_ADDR = 14'h3FFE,
    parameter logic [ADDR_W-1:0] IRQ_VEC_ADDR = 14'h3FFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_fromRAM,
    input  logic              interrupt,
    input  logic              irq_en,
    output logic              wrEn,
    output logic [ADDR_W-1:0] addr_toRAM,
    output logic [DATA_W-1:0] data_toRAM,
    output logic              irq_ack,
    output logic              in_isr
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_OPA    = 3'd2,
        S_EXEC   = 3'd3,
        S_IND    = 3'd4,
        S_IRQ0   = 3'd5,
        S_IRQ1   = 3'd6,
        S_IRQ2   = 3'd7
    } state_t;

    // Operation class is op[3:1]; op[0] selects the immediate form.
    localparam logic [2:0] c_OP_ADD  = 3'd0;
    localparam logic [2:0] c_OP_NAND = 3'd1;
    localparam logic [2:0] c_OP_SRL  = 3'd2;
    localparam logic [2:0] c_OP_LT   = 3'd3;
    localparam logic [2:0] c_OP_CP   = 3'd4;
    localparam logic [2:0] c_OP_CPI  = 3'd5;
    localparam logic [2:0] c_OP_BZJ  = 3'd6;
    localparam logic [2:0] c_OP_MUL  = 3'd7;

    localparam logic [DATA_W-1:0] c_DATA_W_V = DATA_W'(DATA_W);
    localparam logic [ADDR_W-1:0] c_PC_ONE   = ADDR_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [3:0]        r_op;
    logic [ADDR_W-1:0] r_a;
    logic [ADDR_W-1:0] r_b;
    logic [DATA_W-1:0] r_r1;
    logic [DATA_W-1:0] w_r2;
    logic [DATA_W-1:0] w_result;
    logic              r_irq_prev;
    logic              r_irq_pend;
    logic              w_pend_nxt;
    logic              r_in_isr;
    logic              w_isr_nxt;
    logic              w_irq_edge;
    logic              w_take_irq;

    assign w_pc_inc   = r_pc + c_PC_ONE;
    assign w_r2       = r_op[0] ? {{(DATA_W-ADDR_W){1'b0}}, r_b} : data_fromRAM;
    assign w_irq_edge = interrupt & ~r_irq_prev;
    assign w_take_irq = r_irq_pend & irq_en & ~r_in_isr;
    assign in_isr     = r_in_isr;

    always_comb begin
        w_result = '0;
        case (r_op[3:1])
            c_OP_ADD:  w_result = r_r1 + w_r2;
            c_OP_NAND: w_result = ~(r_r1 & w_r2);
            c_OP_SRL: begin
                if (w_r2 < c_DATA_W_V)
                    w_result = r_r1 >> w_r2;
                else
                    w_result = r_r1 << (w_r2 - c_DATA_W_V);
            end
            c_OP_LT:   w_result = {{(DATA_W-1){1'b0}}, (r_r1 < w_r2)};
            c_OP_CP:   w_result = w_r2;
            c_OP_MUL:  w_result = r_r1 * w_r2;
            default:   w_result = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = S_FETCH;
        w_pc_nxt    = r_pc;
        w_isr_nxt   = r_in_isr;
        w_pend_nxt  = r_irq_pend;
        wrEn        = 1'b0;
        addr_toRAM  = r_pc;
        data_toRAM  = '0;
        irq_ack     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_state_nxt = w_take_irq ? S_IRQ0 : S_DECODE;
            end
            S_DECODE: begin
                // Instruction word is still on the bus; take A straight from it.
                addr_toRAM  = data_fromRAM[2*ADDR_W-1:ADDR_W];
                w_state_nxt = S_OPA;
            end
            S_OPA: begin
                addr_toRAM  = r_b;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                addr_toRAM = r_a;
                w_pc_nxt   = w_pc_inc;
                case (r_op[3:1])
                    c_OP_CPI: begin
                        if (!r_op[0]) begin
                            addr_toRAM  = data_fromRAM[ADDR_W-1:0];
                            w_pc_nxt    = r_pc;
                            w_state_nxt = S_IND;
                        end else begin
                            wrEn       = 1'b1;
                            addr_toRAM = r_r1[ADDR_W-1:0];
                            data_toRAM = data_fromRAM;
                        end
                    end
                    c_OP_BZJ: begin
                        if (r_op[0]) begin
                            w_pc_nxt = r_r1[ADDR_W-1:0] + r_b;
                        end else if (data_fromRAM == '0) begin
                            w_pc_nxt = r_r1[ADDR_W-1:0];
                            // A taken branch through the saved-PC word is the ISR return.
                            if (r_in_isr && (r_a == IRQ_RET_ADDR))
                                w_isr_nxt = 1'b0;
                        end
                    end
                    default: begin
                        wrEn       = 1'b1;
                        data_toRAM = w_result;
                    end
                endcase
            end
            S_IND: begin
                wrEn       = 1'b1;
                addr_toRAM = r_a;
                data_toRAM = data_fromRAM;
                w_pc_nxt   = w_pc_inc;
            end
            S_IRQ0: begin
                wrEn        = 1'b1;
                addr_toRAM  = IRQ_RET_ADDR;
                data_toRAM  = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
                irq_ack     = 1'b1;
                w_isr_nxt   = 1'b1;
                w_pend_nxt  = 1'b0;
                w_state_nxt = S_IRQ1;
            end
            S_IRQ1: begin
                addr_toRAM  = IRQ_VEC_ADDR;
                w_state_nxt = S_IRQ2;
            end
            S_IRQ2: begin
                w_pc_nxt = data_fromRAM[ADDR_W-1:0];
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
        // An edge seen in IRQ0 is a new request and must survive the clear.
        if (w_irq_edge)
            w_pend_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_pc       <= '0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_r1       <= '0;
            r_irq_prev <= 1'b0;
            r_irq_pend <= 1'b0;
            r_in_isr   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_irq_prev <= interrupt;
            r_irq_pend <= w_pend_nxt;
            r_in_isr   <= w_isr_nxt;
            if (r_state == S_DECODE) begin
                r_op <= data_fromRAM[DATA_W-1:DATA_W-4];
                r_a  <= data_fromRAM[2*ADDR_W-1:ADDR_W];
                r_b  <= data_fromRAM[ADDR_W-1:0];
            end
            if (r_state == S_OPA)
                r_r1 <= data_fromRAM;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vscpu_irq_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vscpu_irq_core                                                        |
// | Bench for vscpu_irq_core with a synchronous RAM model and write queue.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vscpu_irq_core;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_ADDI   = 4'd1;
    localparam logic [3:0] OP_NAND   = 4'd2;
    localparam logic [3:0] OP_SRLI   = 4'd5;
    localparam logic [3:0] OP_LT     = 4'd6;
    localparam logic [3:0] OP_LTI    = 4'd7;
    localparam logic [3:0] OP_CP_IMM = 4'd9;
    localparam logic [3:0] OP_CPI    = 4'd10;
    localparam logic [3:0] OP_CPI_IM = 4'd11;
    localparam logic [3:0] OP_BZJ    = 4'd12;
    localparam logic [3:0] OP_BZJI   = 4'd13;
    localparam logic [3:0] OP_MULI   = 4'd15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_fromRAM;
    logic        interrupt = 1'b0;
    logic        irq_en = 1'b0;
    logic        wrEn;
    logic [13:0] addr_toRAM;
    logic [31:0] data_toRAM;
    logic        irq_ack;
    logic        in_isr;

    logic [31:0] mem [0:16383];
    logic        tb_we = 1'b0;
    logic [13:0] tb_waddr = '0;
    logic [31:0] tb_wdata = '0;

    typedef struct packed {
        logic [13:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_ack   = 0;

    vscpu_irq_core #(.ADDR_W(14), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_fromRAM (data_fromRAM),
        .interrupt    (interrupt),
        .irq_en       (irq_en),
        .wrEn         (wrEn),
        .addr_toRAM   (addr_toRAM),
        .data_toRAM   (data_toRAM),
        .irq_ack      (irq_ack),
        .in_isr       (in_isr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_we)
            mem[tb_waddr] <= tb_wdata;
        else if (wrEn)
            mem[addr_toRAM] <= data_toRAM;
        data_fromRAM <= mem[addr_toRAM];
    end

    // Every DUT write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wrEn === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_write addr=%h data=%h required=no write", addr_toRAM, data_toRAM);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (addr_toRAM !== e.a || data_toRAM !== e.d) begin
                    n_fail++;
                    $display("FAIL sb_write addr=%h data=%h required addr=%h data=%h", addr_toRAM, data_toRAM, e.a, e.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout cyc=%0d required=finish", cyc);
        $fatal(1);
    end

    function automatic logic [31:0] instr(input logic [3:0] op, input logic [13:0] a, input logic [13:0] b);
        return {op, a, b};
    endfunction

    task automatic push(input logic [13:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        interrupt = 1'b0;
        irq_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load(input logic [13:0] a, input logic [31:0] d);
        tb_we = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic go();
        @(negedge clk);
        rst = 1'b0;
        cyc = 1;
        n_ack = 0;
    endtask

    task automatic to_cycle(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
            if (irq_ack === 1'b1) n_ack++;
        end
    endtask

    task automatic test_reset();
        hold_reset();
        n_tests += 5;
        if (wrEn !== 1'b0) begin n_fail++; $display("FAIL rst_wrEn got=%b required=0", wrEn); end
        if (addr_toRAM !== 14'h0) begin n_fail++; $display("FAIL rst_addr got=%h required=0", addr_toRAM); end
        if (data_toRAM !== 32'h0) begin n_fail++; $display("FAIL rst_data got=%h required=0", data_toRAM); end
        if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL rst_irq_ack got=%b required=0", irq_ack); end
        if (in_isr !== 1'b0) begin n_fail++; $display("FAIL rst_in_isr got=%b required=0", in_isr); end
    endtask

    task automatic test_add();
        hold_reset();
        load(14'd0, instr(OP_ADD, 14'd100, 14'd101));
        load(14'd1, instr(OP_BZJI, 14'd500, 14'd0));
        load(14'd100, 32'd5);
        load(14'd101, 32'd7);
        load(14'd500, 32'd1);
        push(14'd100, 32'd12);
        go();
        n_tests++;
        if (addr_toRAM !== 14'd0) begin n_fail++; $display("FAIL add_first_fetch addr=%h required=0", addr_toRAM); end
        to_cycle(4);
        n_tests += 3;
        if (wrEn !== 1'b1) begin n_fail++; $display("FAIL add_wrEn_c4 got=%b required=1", wrEn); end
        if (addr_toRAM !== 14'd100) begin n_fail++; $display("FAIL add_addr_c4 got=%h required=100", addr_toRAM); end
        if (data_toRAM !== 32'd12) begin n_fail++; $display("FAIL add_data_c4 got=%h required=12", data_toRAM); end
        to_cycle(5);
        n_tests++;
        if (addr_toRAM !== 14'd1) begin n_fail++; $display("FAIL add_next_fetch addr=%h required=1", addr_toRAM); end
        to_cycle(12);
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL add_drain pending=%0d required=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_alu();
        hold_reset();
        load(14'd0, instr(OP_SRLI, 14'd100, 14'd34));
        load(14'd1, instr(OP_SRLI, 14'd101, 14'd3));
        load(14'd2, instr(OP_MULI, 14'd102, 14'd3));
        load(14'd3, instr(OP_NAND, 14'd103, 14'd104));
        load(14'd4, instr(OP_LT, 14'd105, 14'd106));
        load(14'd5, instr(OP_LTI, 14'd107, 14'd2));
        load(14'd6, instr(OP_CP_IMM, 14'd108, 14'h1234));
        load(14'd7, instr(OP_BZJI, 14'd500, 14'd0));
        load(14'd100, 32'd1);
        load(14'd101, 32'd16);
        load(14'd102, 32'h8000_0001);
        load(14'd103, 32'hF0F0_F0F0);
        load(14'd104, 32'hFF00_FF00);
        load(14'd105, 32'd3);
        load(14'd106, 32'd5);
        load(14'd107, 32'd5);
        load(14'd108, 32'd0);
        load(14'd500, 32'd7);
        push(14'd100, 32'd4);
        push(14'd101, 32'd2);
        push(14'd102, 32'h8000_0003);
        push(14'd103, 32'h0FFF_0FFF);
        push(14'd105, 32'd1);
        push(14'd107, 32'd0);
        push(14'd108, 32'h0000_1234);
        go();
        to_cycle(29);
        n_tests += 3;
        if (addr_toRAM !== 14'd7) begin n_fail++; $display("FAIL alu_fetch_c29 addr=%h required=7", addr_toRAM); end
        if (mem[100] !== 32'd4) begin n_fail++; $display("FAIL alu_srl_big mem=%h required=4", mem[100]); end
        if (mem[102] !== 32'h8000_0003) begin n_fail++; $display("FAIL alu_mul mem=%h required=80000003", mem[102]); end
        to_cycle(34);
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL alu_drain pending=%0d required=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_branch_indirect();
        hold_reset();
        load(14'd0, instr(OP_CPI, 14'd200, 14'd201));
        load(14'd1, instr(OP_BZJ, 14'd202, 14'd203));
        load(14'd50, instr(OP_CPI_IM, 14'd204, 14'd205));
        load(14'd51, instr(OP_BZJ, 14'd206, 14'd207));
        load(14'd52, instr(OP_BZJI, 14'd208, 14'd5));
        load(14'd65, instr(OP_ADDI, 14'd209, 14'h3FFF));
        load(14'd66, instr(OP_BZJI, 14'd210, 14'd0));
        load(14'd200, 32'd0);
        load(14'd201, 32'd300);
        load(14'd300, 32'd9);
        load(14'd202, 32'd50);
        load(14'd203, 32'd0);
        load(14'd204, 32'd400);
        load(14'd205, 32'd77);
        load(14'd206, 32'd99);
        load(14'd207, 32'd1);
        load(14'd208, 32'd60);
        load(14'd209, 32'hFFFF_FFFF);
        load(14'd210, 32'd66);
        push(14'd200, 32'd9);
        push(14'd400, 32'd77);
        push(14'd209, 32'h0000_3FFE);
        go();
        to_cycle(5);
        n_tests += 2;
        if (wrEn !== 1'b1) begin n_fail++; $display("FAIL cpi_wrEn_c5 got=%b required=1", wrEn); end
        if (addr_toRAM !== 14'd200) begin n_fail++; $display("FAIL cpi_addr_c5 got=%h required=200", addr_toRAM); end
        to_cycle(6);
        n_tests++;
        if (addr_toRAM !== 14'd1) begin n_fail++; $display("FAIL cpi_next_fetch addr=%h required=1", addr_toRAM); end
        to_cycle(9);
        n_tests++;
        if (wrEn !== 1'b0) begin n_fail++; $display("FAIL bzj_no_write got=%b required=0", wrEn); end
        to_cycle(10);
        n_tests++;
        if (addr_toRAM !== 14'd50) begin n_fail++; $display("FAIL bzj_taken addr=%h required=50", addr_toRAM); end
        to_cycle(18);
        n_tests++;
        if (addr_toRAM !== 14'd52) begin n_fail++; $display("FAIL bzj_not_taken addr=%h required=52", addr_toRAM); end
        to_cycle(22);
        n_tests++;
        if (addr_toRAM !== 14'd65) begin n_fail++; $display("FAIL bzji_target addr=%h required=65", addr_toRAM); end
        to_cycle(26);
        n_tests += 2;
        if (addr_toRAM !== 14'd66) begin n_fail++; $display("FAIL addi_next_fetch addr=%h required=66", addr_toRAM); end
        if (mem[400] !== 32'd77) begin n_fail++; $display("FAIL cpii_mem mem=%h required=77", mem[400]); end
        to_cycle(32);
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL br_drain pending=%0d required=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_irq_entry_return();
        hold_reset();
        load(14'd0, instr(OP_ADDI, 14'd100, 14'd1));
        load(14'd1, instr(OP_ADDI, 14'd100, 14'd1));
        load(14'd2, instr(OP_ADDI, 14'd100, 14'd1));
        load(14'd3, instr(OP_ADDI, 14'd101, 14'd5));
        load(14'd4, instr(OP_BZJI, 14'd300, 14'd0));
        load(14'd40, instr(OP_ADDI, 14'd102, 14'd7));
        load(14'd41, instr(OP_BZJ, 14'h3FFE, 14'd103));
        load(14'd100, 32'd0);
        load(14'd101, 32'd0);
        load(14'd102, 32'd0);
        load(14'd103, 32'd0);
        load(14'd300, 32'd4);
        load(14'h3FFF, 32'd40);
        push(14'd100, 32'd1);
        push(14'd100, 32'd2);
        push(14'd100, 32'd3);
        push(14'd101, 32'd5);
        push(14'h3FFE, 32'd4);
        push(14'd102, 32'd7);
        irq_en = 1'b1;
        go();
        to_cycle(14);
        interrupt = 1'b1;
        to_cycle(18);
        n_tests += 3;
        if (irq_ack !== 1'b1) begin n_fail++; $display("FAIL irq_ack_c18 got=%b required=1", irq_ack); end
        if (addr_toRAM !== 14'h3FFE) begin n_fail++; $display("FAIL irq_save_addr got=%h required=3ffe", addr_toRAM); end
        if (mem[101] !== 32'd5) begin n_fail++; $display("FAIL irq_instr3_done mem=%h required=5", mem[101]); end
        to_cycle(19);
        n_tests += 3;
        if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL irq_ack_pulse got=%b required=0", irq_ack); end
        if (in_isr !== 1'b1) begin n_fail++; $display("FAIL irq_in_isr got=%b required=1", in_isr); end
        if (addr_toRAM !== 14'h3FFF) begin n_fail++; $display("FAIL irq_vec_addr got=%h required=3fff", addr_toRAM); end
        to_cycle(21);
        n_tests++;
        if (addr_toRAM !== 14'd40) begin n_fail++; $display("FAIL irq_isr_fetch addr=%h required=40", addr_toRAM); end
        to_cycle(28);
        n_tests++;
        if (in_isr !== 1'b1) begin n_fail++; $display("FAIL irq_isr_held got=%b required=1", in_isr); end
        to_cycle(29);
        n_tests += 3;
        if (addr_toRAM !== 14'd4) begin n_fail++; $display("FAIL irq_return_fetch addr=%h required=4", addr_toRAM); end
        if (in_isr !== 1'b0) begin n_fail++; $display("FAIL irq_return_isr got=%b required=0", in_isr); end
        if (mem[14'h3FFE] !== 32'd4) begin n_fail++; $display("FAIL irq_saved_pc mem=%h required=4", mem[14'h3FFE]); end
        interrupt = 1'b0;
        to_cycle(36);
        n_tests += 2;
        if (n_ack != 1) begin n_fail++; $display("FAIL irq_ack_count got=%0d required=1", n_ack); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL irq_drain pending=%0d required=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_irq_mask_nested();
        hold_reset();
        load(14'd0, instr(OP_BZJI, 14'd300, 14'd0));
        load(14'd40, instr(OP_ADDI, 14'd102, 14'd1));
        load(14'd41, instr(OP_BZJ, 14'h3FFE, 14'd103));
        load(14'd102, 32'd0);
        load(14'd103, 32'd0);
        load(14'd300, 32'd0);
        load(14'h3FFF, 32'd40);
        push(14'h3FFE, 32'd0);
        push(14'd102, 32'd1);
        push(14'h3FFE, 32'd0);
        push(14'd102, 32'd2);
        go();
        to_cycle(2);
        interrupt = 1'b1;
        to_cycle(4);
        interrupt = 1'b0;
        to_cycle(22);
        n_tests += 2;
        if (n_ack != 0) begin n_fail++; $display("FAIL mask_no_entry acks=%0d required=0", n_ack); end
        if (in_isr !== 1'b0) begin n_fail++; $display("FAIL mask_in_isr got=%b required=0", in_isr); end
        irq_en = 1'b1;
        to_cycle(26);
        n_tests++;
        if (irq_ack !== 1'b1) begin n_fail++; $display("FAIL unmask_entry_c26 got=%b required=1", irq_ack); end
        to_cycle(30);
        interrupt = 1'b1;
        n_tests++;
        if (in_isr !== 1'b1) begin n_fail++; $display("FAIL nested_in_isr got=%b required=1", in_isr); end
        to_cycle(37);
        n_tests += 2;
        if (addr_toRAM !== 14'd0) begin n_fail++; $display("FAIL nested_return addr=%h required=0", addr_toRAM); end
        if (in_isr !== 1'b0) begin n_fail++; $display("FAIL nested_return_isr got=%b required=0", in_isr); end
        to_cycle(38);
        n_tests++;
        if (irq_ack !== 1'b1) begin n_fail++; $display("FAIL nested_second_entry got=%b required=1", irq_ack); end
        interrupt = 1'b0;
        to_cycle(49);
        n_tests += 3;
        if (addr_toRAM !== 14'd0 || in_isr !== 1'b0) begin n_fail++; $display("FAIL nested_final addr=%h isr=%b required addr=0 isr=0", addr_toRAM, in_isr); end
        if (mem[102] !== 32'd2) begin n_fail++; $display("FAIL nested_isr_count mem=%h required=2", mem[102]); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL nested_drain pending=%0d required=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_in_irq();
        hold_reset();
        load(14'd0, instr(OP_BZJI, 14'd300, 14'd0));
        load(14'd300, 32'd0);
        load(14'h3FFF, 32'd40);
        push(14'h3FFE, 32'd0);
        irq_en = 1'b1;
        go();
        to_cycle(2);
        interrupt = 1'b1;
        to_cycle(6);
        n_tests++;
        if (irq_ack !== 1'b1) begin n_fail++; $display("FAIL rirq_entry_c6 got=%b required=1", irq_ack); end
        to_cycle(7);
        n_tests++;
        if (addr_toRAM !== 14'h3FFF) begin n_fail++; $display("FAIL rirq_irq1_addr got=%h required=3fff", addr_toRAM); end
        rst = 1'b1;
        interrupt = 1'b0;
        @(negedge clk);
        n_tests += 3;
        if (addr_toRAM !== 14'd0 || wrEn !== 1'b0) begin n_fail++; $display("FAIL rirq_state addr=%h wrEn=%b required addr=0 wrEn=0", addr_toRAM, wrEn); end
        if (in_isr !== 1'b0) begin n_fail++; $display("FAIL rirq_in_isr got=%b required=0", in_isr); end
        if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL rirq_ack got=%b required=0", irq_ack); end
        go();
        to_cycle(13);
        n_tests += 3;
        if (n_ack != 0) begin n_fail++; $display("FAIL rirq_pending_cleared acks=%0d required=0", n_ack); end
        if (addr_toRAM !== 14'd0) begin n_fail++; $display("FAIL rirq_fetch addr=%h required=0", addr_toRAM); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rirq_drain pending=%0d required=0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu();
        test_branch_indirect();
        test_irq_entry_return();
        test_irq_mask_nested();
        test_reset_in_irq();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vscpu_irq_core.md
VSCPU_IRQ_CORE -- requirements
Module: vscpu_irq_core

Interface
REQ-001 Parameter ADDR_W, default 14, memory word-address width; PC and the A/B instruction fields are ADDR_W bits.
REQ-002 Parameter DATA_W, default 32, data and instruction width; the configuration SHALL satisfy DATA_W >= 2*ADDR_W+4.
REQ-003 Parameter IRQ_RET_ADDR, default 14'h3FFE, word where the interrupted PC is saved.
REQ-004 Parameter IRQ_VEC_ADDR, default 14'h3FFF, word holding the interrupt service routine start address.
REQ-005 clk  in  1  sole clock, rising edge; one clock; reset is synchronous and active-high.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 data_fromRAM  in  DATA_W  read data; valid one cycle after addr_toRAM is presented (synchronous RAM).
REQ-008 interrupt  in  1  interrupt request, level input, rising edge is significant.
REQ-009 irq_en  in  1  global interrupt enable.
REQ-010 wrEn  out  1  RAM write strobe, combinational from state.
REQ-011 addr_toRAM  out  ADDR_W  RAM address, combinational.
REQ-012 data_toRAM  out  DATA_W  RAM write data, combinational; 0 when wrEn=0.
REQ-013 irq_ack  out  1  one-cycle pulse on interrupt entry.
REQ-014 in_isr  out  1  registered; high while the service routine runs.

Function
REQ-015 Instruction fields: op = IW[DATA_W-1:DATA_W-4] (bit DATA_W-4 = immediate flag), A = IW[2*ADDR_W-1:ADDR_W], B = IW[ADDR_W-1:0]; immediates zero-extended to DATA_W.
REQ-016 R1 = mem[A]; R2 = mem[B] (op imm=0) or B (imm=1); results truncated to DATA_W.
REQ-017 Opcodes 0-7: ADD mem[A]<=R1+R2; NAND mem[A]<=~(R1&R2); SRL mem[A]<=(R2<DATA_W)?R1>>R2:R1<<(R2-DATA_W); LT mem[A]<=(R1<R2)?1:0, unsigned.
REQ-018 CP/CPi mem[A]<=R2; CPI mem[A]<=mem[mem[B]]; CPIi mem[mem[A]]<=mem[B]; MUL/MULi mem[A]<=low DATA_W bits of R1*R2.
REQ-019 BZJ PC<=(mem[B]==0)?mem[A]:PC+1; BZJi PC<=mem[A]+B; all PC arithmetic modulo 2^ADDR_W; all non-branch ops PC<=PC+1.
REQ-020 States: FETCH (addr=PC) -> DECODE (IW<=data, addr=A) -> OPA (R1<=data, addr=B) -> EXEC (execute with R2 from data_fromRAM or B, write/branch) -> FETCH.
REQ-021 CPI: EXEC drives addr=data_fromRAM, goes to IND; IND writes mem[A]<=data_fromRAM, PC+1 -> FETCH.
REQ-022 CPIi: EXEC writes addr=R1[ADDR_W-1:0], data=mem[B].
REQ-023 Latency: 4 cycles per instruction, CPI 5 cycles; exactly one wrEn cycle per non-branch instruction, none for BZJ/BZJi.
REQ-024 irq_pending set on a rising edge of interrupt (registered previous sample); edges during a pending or ISR state are not queued beyond one.
REQ-025 Interrupt entry checked only in FETCH: if irq_pending && irq_en && !in_isr, go to IRQ0 instead of DECODE, no instruction executed.
REQ-026 IRQ0: wrEn=1, addr=IRQ_RET_ADDR, data=PC (zero-extended); irq_ack=1; irq_pending<=0; in_isr<=1. IRQ1: addr=IRQ_VEC_ADDR. IRQ2: PC<=data_fromRAM[ADDR_W-1:0] -> FETCH.
REQ-027 Return: a BZJ executed while in_isr=1 whose A equals IRQ_RET_ADDR and whose branch is taken SHALL clear in_isr in the same EXEC cycle.
REQ-028 Simultaneous rising edge and entry in same cycle: pending SHALL end cleared (entry wins); an edge arriving during IRQ0-IRQ2 or in_isr=1 SHALL set pending for service after return.
REQ-029 Unreachable/illegal state encodings SHALL return to FETCH.

Reset
REQ-030 On rst=1 at a clock edge: state=FETCH, PC=0, IW=R1=0, irq_pending=0, in_isr=0, previous interrupt sample=0; rst overrides all other activity including an in-progress write or interrupt entry.
REQ-031 After reset: wrEn=0, addr_toRAM=0, data_toRAM=0, irq_ack=0, in_isr=0; first fetch from address 0 on the first cycle after rst deasserts.

Verification
REQ-032 mem[0]=ADD A=100 B=101, mem[100]=5, mem[101]=7 -> cycle 4 wrEn=1 addr=100 data=12, next fetch addr 1.
REQ-033 SRLi A=100 B=34, mem[100]=1 -> mem[100]=4; SRLi B=3, mem[100]=16 -> 2; MULi B=3, mem[100]=32'h8000_0001 -> 32'h8000_0003.
REQ-034 CPI A=200 B=201, mem[201]=300, mem[300]=9 -> 5 cycles, mem[200]=9; BZJ with mem[B]=0, mem[A]=50 -> PC=50, no wrEn.
REQ-035 irq_en=1, interrupt edge during instruction at PC=3, mem[3FFF]=40 -> instruction at 3 completes, irq_ack pulse, mem[3FFE]=4, next fetch addr 40; BZJ A=3FFE to zero word -> fetch 4, in_isr=0.
REQ-036 Edge while irq_en=0 -> no entry; raise irq_en later -> entry at next FETCH; second edge inside ISR -> serviced after return.
REQ-037 rst asserted during IRQ1 -> next cycle state FETCH, PC=0, in_isr=0, irq_pending=0.
